// File: rtl/pipe_skid_pkg.sv
// Shared types for the two-entry elastic pipeline register.
// State encoding and its width live here so every user agrees on them.
package pipe_skid_pkg;

  localparam int unsigned PIPE_SKID_STATE_W = 2;

  typedef enum logic [PIPE_SKID_STATE_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_skid_state_t;

  // Number of words held in a given state.
  function automatic logic [1:0] occupancy(
    input pipe_skid_state_t s
  );
    logic [1:0] n;
    n = 2'd0;
    unique case (s)
      ONE:     n = 2'd1;
      FULL:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Control for the two-entry skid register: state, handshake decode, loads.
// Flush term present only when PIPE_SKID_FLUSH_EN is defined.
module pipe_skid_ctrl
  import pipe_skid_pkg::*;
(
  input  logic clk,
  input  logic arst_n,
  input  logic in_valid,
  input  logic out_ready,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic flush,
`endif
  output logic in_ready,
  output logic out_valid,
  output logic ld_main,
  output logic ld_skid,
  output logic sel_skid
);

  pipe_skid_state_t state_q;
  pipe_skid_state_t state_d;
  logic             in_fire;
  logic             out_fire;
  logic             kill;

  // Ready/valid come straight from the state register.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef PIPE_SKID_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: occupancy follows push/pop, kill empties.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) state_d = ONE;
      end
      ONE: begin
        unique case (1'b1)
          in_fire & out_fire:   state_d = ONE;
          in_fire & !out_fire:  state_d = FULL;
          !in_fire & out_fire:  state_d = EMPTY;
          default:              state_d = ONE;
        endcase
      end
      FULL: begin
        if (out_fire) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (kill) state_d = EMPTY;
  end

  // Data-register load enables; nothing loads in a flush cycle.
  always_comb begin
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    sel_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        ld_main = in_fire;
      end
      ONE: begin
        ld_main = in_fire & out_fire;
        ld_skid = in_fire & !out_fire;
      end
      FULL: begin
        ld_main  = out_fire;
        sel_skid = 1'b1;
      end
      default: begin
        ld_main = 1'b0;
      end
    endcase
    if (kill) begin
      ld_main = 1'b0;
      ld_skid = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_skid_arstn.sv
// Two-entry elastic pipeline register with registered backpressure.
// Optional flush port enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_arstn
  import pipe_skid_pkg::*;
#(
  parameter int unsigned           DATA_W     = 32,
  parameter logic [DATA_W-1:0]     PRESET_VAL = '0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic              flush,
`endif
  output logic [DATA_W-1:0] out_data
);

  logic              ld_main;
  logic              ld_skid;
  logic              sel_skid;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] main_d;

  pipe_skid_ctrl u_ctrl (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .out_ready (out_ready),
`ifdef PIPE_SKID_FLUSH_EN
    .flush     (flush),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .ld_main   (ld_main),
    .ld_skid   (ld_skid),
    .sel_skid  (sel_skid)
  );

  // Main refills from skid when draining FULL, else from upstream.
  always_comb begin
    main_d = sel_skid ? skid_q : in_data;
  end

  // Output-side register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      main_q <= PRESET_VAL;
    end else if (ld_main) begin
      main_q <= main_d;
    end
  end

  // Overflow register, only written when main is stalled.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      skid_q <= PRESET_VAL;
    end else if (ld_skid) begin
      skid_q <= in_data;
    end
  end

  assign out_data = main_q;

endmodule
